// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture path: FSM states, default
// geometry and the RGB565 -> RGB332 bit slicing.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_BYTE1,
    ST_BYTE2,
    ST_DONE
  } cap_state_t;

  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;
  localparam int PIXELS    = IMG_W_DEF * IMG_H_DEF;

  // Byte 1 carries R[4:0]:G[5:3], byte 2 carries G[2:0]:B[4:0]
  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 2;
  localparam int G_LO = 0;
  localparam int B_HI = 4;
  localparam int B_LO = 3;

  function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[R_HI:R_LO], hi[G_HI:G_LO], lo[B_HI:B_LO]};
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rise/fall pulse generator: one registered history bit, pulses valid in the
// cycle the input differs from its previous sample.
module edge_detect (
  input  logic clk_i,
  input  logic arst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/ov7670_pixel_capture.sv
// Packs the registered OV7670 RGB565 byte stream into RGB332 frame-buffer writes.
// Define LINE_CHECK_EN to add the sticky line_err geometry checker.
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = 15
) (
  input  logic          pclk,
  input  logic          async_reset,
  input  logic          init_cap,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_byte,
  output logic [AW-1:0] mem_px_addr,
  output logic [7:0]    mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic          frame_done
`ifdef LINE_CHECK_EN
  ,
  output logic          line_err
`endif
);

  localparam int            NPIX      = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  cap_state_t    state_q;
  logic [7:0]    b1_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    data_q;
  logic          wr_q;
  logic          busy_q;
  logic          done_q;
  logic          full_q;

  logic vsync_rise, vsync_fall;
  logic href_rise_unused, href_fall;

  edge_detect u_vsync_edge (
    .clk_i (pclk),
    .arst_i(async_reset),
    .sig_i (vsync),
    .rise_o(vsync_rise),
    .fall_o(vsync_fall)
  );

  edge_detect u_href_edge (
    .clk_i (pclk),
    .arst_i(async_reset),
    .sig_i (href),
    .rise_o(href_rise_unused),
    .fall_o(href_fall)
  );

  always_ff @(posedge pclk or posedge async_reset) begin
    if (async_reset) begin
      state_q <= ST_IDLE;
      b1_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      // Address advances after each write and parks on the last pixel
      if (wr_q) begin
        if (addr_q == LAST_ADDR) full_q <= 1'b1;
        else                     addr_q <= addr_q + 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (init_cap) begin
            state_q <= ST_WAIT_SOF;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            full_q  <= 1'b0;
          end
        end
        ST_WAIT_SOF: begin
          if (vsync_fall) state_q <= ST_BYTE1;
        end
        ST_BYTE1: begin
          if (vsync_rise) begin
            state_q <= ST_DONE;
          end else if (href) begin
            b1_q    <= px_byte;
            state_q <= ST_BYTE2;
          end
        end
        ST_BYTE2: begin
          if (vsync_rise) begin
            state_q <= ST_DONE;
          end else if (href) begin
            if (!full_q) begin
              data_q <= rgb565_to_332(b1_q, px_byte);
              wr_q   <= 1'b1;
            end
            state_q <= ST_BYTE1;
          end else if (href_fall) begin
            // Odd byte count on this line: drop the orphaned first byte
            state_q <= ST_BYTE1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = wr_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

`ifdef LINE_CHECK_EN
  logic [15:0] byte_cnt_q;
  logic [15:0] line_cnt_q;
  logic        line_err_q;
  logic        capturing;
  logic [15:0] lines_total;

  assign capturing   = (state_q == ST_BYTE1) || (state_q == ST_BYTE2);
  assign lines_total = line_cnt_q + 16'(href_fall);

  always_ff @(posedge pclk or posedge async_reset) begin
    if (async_reset) begin
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      line_err_q <= 1'b0;
    end else if (state_q == ST_IDLE && init_cap) begin
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      line_err_q <= 1'b0;
    end else if (capturing) begin
      if (href_fall) begin
        if (byte_cnt_q != 16'(2 * IMG_W)) line_err_q <= 1'b1;
        line_cnt_q <= lines_total;
        byte_cnt_q <= '0;
      end else if (href && !vsync_rise) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end
      if (vsync_rise && lines_total != 16'(IMG_H)) line_err_q <= 1'b1;
    end
  end

  assign line_err = line_err_q;
`endif

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Scoreboard bench for ov7670_pixel_capture: stimulus queues expected writes,
// a negedge monitor pops and compares every px_wr pulse.
module tb_ov7670_pixel_capture;

  localparam int AW   = 15;
  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  logic          pclk;
  logic          async_reset;
  logic          init_cap;
  logic          vsync;
  logic          href;
  logic [7:0]    px_byte;
  logic [AW-1:0] mem_px_addr;
  logic [7:0]    mem_px_data;
  logic          px_wr;
  logic          busy;
  logic          frame_done;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  bit verbose = 1'b1;
  logic [AW+7:0] sb[$];

  ov7670_pixel_capture #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .pclk       (pclk),
    .async_reset(async_reset),
    .init_cap   (init_cap),
    .vsync      (vsync),
    .href       (href),
    .px_byte    (px_byte),
    .mem_px_addr(mem_px_addr),
    .mem_px_data(mem_px_data),
    .px_wr      (px_wr),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp332(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[7:5], b1[2:0], b2[4:3]};
  endfunction

  // Monitor: every write must match the oldest queued expectation
  always @(negedge pclk) begin
    if (px_wr === 1'b1) begin
      wr_count++;
      if (sb.size() == 0) begin
        chk("unexpected_px_wr_addr", 32'(mem_px_addr), 32'hFFFF_FFFF);
      end else begin
        logic [AW+7:0] e;
        e = sb.pop_front();
        chk("px_addr", 32'(mem_px_addr), 32'(e[AW+7:8]));
        chk("px_data", 32'(mem_px_data), 32'(e[7:0]));
        if (verbose) $display("write addr=%0d data=%02h", mem_px_addr, mem_px_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic arm();
    init_cap = 1'b1;
    tick(1);
    init_cap = 1'b0;
    chk("busy_after_arm", 32'(busy), 32'd1);
  endtask

  task automatic start_frame();
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(2);
  endtask

  task automatic send_pair(input logic [7:0] b1, input logic [7:0] b2, input logic push,
                           input logic [7:0] exp_d, input int exp_a);
    logic [AW-1:0] a;
    a = exp_a[AW-1:0];
    href = 1'b1;
    px_byte = b1;
    tick(1);
    px_byte = b2;
    if (push) sb.push_back({a, exp_d});
    tick(1);
  endtask

  task automatic line_gap();
    href = 1'b0;
    tick(2);
  endtask

  task automatic end_frame(input string name);
    bit seen;
    seen = 1'b0;
    href = 1'b0;
    vsync = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick(1);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    chk({name, "_frame_done_seen"}, 32'(seen), 32'd1);
    tick(1);
    chk({name, "_frame_done_one_cycle"}, 32'(frame_done), 32'd0);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    chk({name, "_scoreboard_drained"}, 32'(sb.size()), 32'd0);
    $display("frame %s ended, writes so far %0d", name, wr_count);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    async_reset = 1'b1;
    init_cap = 1'b0;
    vsync = 1'b1;
    href = 1'b0;
    px_byte = 8'h00;
    tick(2);
    chk("reset_addr", 32'(mem_px_addr), 32'd0);
    chk("reset_data", 32'(mem_px_data), 32'd0);
    chk("reset_wr", 32'(px_wr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(frame_done), 32'd0);
    async_reset = 1'b0;
    tick(2);

    // Directed pixels with hand-computed RGB332 values
    arm();
    start_frame();
    send_pair(8'hE7, 8'h18, 1'b1, 8'hFF, 0);
    send_pair(8'h12, 8'h34, 1'b1, 8'h0A, 1);
    send_pair(8'hA5, 8'h5A, 1'b1, 8'hB7, 2);
    send_pair(8'h00, 8'hFF, 1'b1, 8'h03, 3);
    line_gap();
    chk("addr_after_4_writes", 32'(mem_px_addr), 32'd4);
    end_frame("directed");

    // Asynchronous reset while waiting for byte 2
    arm();
    start_frame();
    href = 1'b1;
    px_byte = 8'hAA;
    tick(1);
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2 async_reset = 1'b1;
    #1;
    chk("midreset_addr", 32'(mem_px_addr), 32'd0);
    chk("midreset_data", 32'(mem_px_data), 32'd0);
    chk("midreset_wr", 32'(px_wr), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(frame_done), 32'd0);
    tick(1);
    async_reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      px_byte = 8'(i * 37);
      tick(1);
    end
    href = 1'b0;
    chk("busy_after_reset", 32'(busy), 32'd0);
    vsync = 1'b1;
    tick(2);

    // Odd line: 319 bytes gives 159 pixels, next line continues at 159
    arm();
    start_frame();
    for (int i = 0; i < 159; i++)
      send_pair(8'(i), 8'(~i), 1'b1, exp332(8'(i), 8'(~i)), i);
    px_byte = 8'h77;
    tick(1);
    line_gap();
    send_pair(8'hFF, 8'h00, 1'b1, 8'hFC, 159);
    send_pair(8'h40, 8'h08, 1'b1, 8'h41, 160);
    line_gap();
    end_frame("odd_line");

    // Arming mid-frame: bytes before the next vsync fall must be ignored
    vsync = 1'b0;
    tick(2);
    href = 1'b1;
    init_cap = 1'b1;
    px_byte = 8'h55;
    tick(1);
    init_cap = 1'b0;
    chk("busy_armed_midframe", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) send_pair(8'(i + 1), 8'hF8, 1'b0, 8'h00, 0);
    line_gap();
    for (int i = 0; i < 8; i++) send_pair(8'hC3, 8'(i), 1'b0, 8'h00, 0);
    line_gap();
    start_frame();
    send_pair(8'h81, 8'h10, 1'b1, 8'h86, 0);
    line_gap();
    end_frame("midframe_arm");

    // Full frame plus one overrun line: writes stop at NPIX, address parks
    verbose = 1'b0;
    base = wr_count;
    arm();
    start_frame();
    for (int ln = 0; ln < H + 1; ln++) begin
      for (int x = 0; x < W; x++) begin
        int p;
        logic [7:0] b1, b2;
        p = ln * W + x;
        b1 = 8'(p);
        b2 = 8'(p >> 8);
        send_pair(b1, b2, (ln < H), exp332(b1, b2), p);
      end
      line_gap();
    end
    chk("overrun_write_count", 32'(wr_count - base), 32'(NPIX));
    chk("overrun_addr_hold", 32'(mem_px_addr), 32'(NPIX - 1));
    end_frame("full_overrun");
    chk("addr_after_frame", 32'(mem_px_addr), 32'(NPIX - 1));

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_pixel_capture.md
Name: ov7670_pixel_capture

Overview:
- Capture stage directly downstream of the falling-edge input registers that sample the OV7670 bus (D[7:0], HREF, VSYNC) on PCLK.
- Consumes the registered RGB565 byte stream, packs each byte pair into one RGB332 pixel, and produces write address/data/strobe for the frame-buffer RAM.
- Armed per frame by the control FSM; reports frame completion.

Parameters:
- IMG_W, 160, pixels per line.
- IMG_H, 120, lines per frame.
- AW, 15, frame-buffer address width; must satisfy 2**AW >= IMG_W*IMG_H.

Ports:
- pclk  in  1  camera pixel clock; all logic samples on posedge (upstream registers update on negedge).
- async_reset  in  1  reset, asynchronous, active-high.
- init_cap  in  1  arm capture of the next full frame; level, sampled each posedge.
- vsync  in  1  registered VSYNC; high = vertical blank.
- href  in  1  registered HREF; high = valid byte on px_byte.
- px_byte  in  8  registered camera data byte.
- mem_px_addr  out  AW  frame-buffer write address.
- mem_px_data  out  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}.
- px_wr  out  1  write strobe, one pclk per pixel.
- busy  out  1  high from arming until frame end.
- frame_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, any state): state=IDLE; mem_px_addr=0, mem_px_data=0, px_wr=0, busy=0, frame_done=0; byte-1 holding register=0.
- FSM states: IDLE, WAIT_SOF, BYTE1, BYTE2, DONE.
- IDLE: when init_cap=1 -> WAIT_SOF; set busy=1, mem_px_addr=0.
- WAIT_SOF: start of frame is the falling edge of vsync (previous-cycle vsync=1, current=0); on detection -> BYTE1. A frame already in progress at arming is skipped.
- BYTE1: if href=1, latch px_byte (R5:G3 high) -> BYTE2.
- BYTE2: if href=1, form pixel {b1[7:5], b1[2:0], px_byte[4:3]} -> BYTE1.
  - Registered outputs: mem_px_data=pixel and px_wr=1 on the following cycle (latency 1 pclk after byte 2).
  - mem_px_addr is the current pixel's address while px_wr=1, and increments by 1 the cycle after px_wr.
- href falls while in BYTE2 (odd byte count): discard byte 1, no write, return to BYTE1.
- Address limit: once IMG_W*IMG_H pixels are written, further px_wr is suppressed and the address holds at IMG_W*IMG_H-1.
- vsync rising edge in BYTE1/BYTE2 -> DONE; a pending partial pixel is discarded.
- DONE: frame_done=1 for exactly one cycle, busy=0, -> IDLE.
  - If init_cap is still 1 in IDLE, a new capture re-arms (continuous mode by holding init_cap).
- Simultaneous href=1 and vsync rise: the vsync edge wins and the byte is ignored.
- px_wr is never high in IDLE, WAIT_SOF or DONE.

Optional Feature:
- LINE_CHECK_EN defined:
  - Adds output line_err (1 bit, sticky until the next arming).
  - Adds an internal byte counter per href-high window.
  - line_err=1 if any line in the frame has a byte count != 2*IMG_W, or the frame ends with a line count != IMG_H.
- Undefined: no port, no counters.

Decomposition:
- Shared package ov7670_pkg:
  - FSM state enum.
  - IMG_W/IMG_H defaults.
  - RGB565->RGB332 bit-slice constants.
  - Derived PIXELS = IMG_W*IMG_H.
- Optional sub-module edge_detect (registered rise/fall pulses), instanced for vsync and href.
- Remaining logic stays in one module.

Test Plan:
- Reset mid-frame: assert async_reset during BYTE2 -> all outputs 0 immediately, state IDLE, no px_wr after release.
- Single pixel: arm, vsync 1->0, href=1 with bytes 0xE7, 0x18 -> px_wr one cycle later with mem_px_data=0xE7&... = {111,111,11}=0xFF, addr 0.
- Full frame 160x120 with incrementing pattern -> exactly 19200 px_wr pulses, addresses 0..19199, frame_done pulse at vsync rise, busy low after.
- Odd line: 319 bytes with href high -> 159 writes on that line, the last byte discarded, and the next line starts at the correct address.
- Overrun: 121 lines -> writes stop at 19200, addr holds 19199; under LINE_CHECK_EN line_err=1.
- Arming during active frame: init_cap asserted with vsync=0 mid-frame -> no writes until the next vsync falling edge.
